// File: rtl/sobel_sched_if.sv
// rtl/sobel_sched_if.sv - pixel-in / magnitude-out stream bundle for sobel_sched
// Signals:
//   in_valid/in_ready/in_sof/in_pix   raster pixel stream into the sequencer
//   out_valid/out_ready/out_mag       |Gx|+|Gy| result stream
//   out_x/out_y                       centre coordinate of the reported window
//   thresh/out_edge                   only when SOBEL_THRESH_EN is defined
// Modports: master = sobel_sched side, slave = surrounding environment.
interface sobel_sched_if #(
    parameter int PIX_W = 12,
    parameter int XW    = 10,
    parameter int YW    = 9
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [18:0]      out_mag;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
`ifdef SOBEL_THRESH_EN
    logic [18:0]      thresh;
    logic             out_edge;

    modport master (
        input  in_valid, in_sof, in_pix, out_ready, thresh,
        output in_ready, out_valid, out_mag, out_x, out_y, out_edge
    );
    modport slave (
        output in_valid, in_sof, in_pix, out_ready, thresh,
        input  in_ready, out_valid, out_mag, out_x, out_y, out_edge
    );
`else
    modport master (
        input  in_valid, in_sof, in_pix, out_ready,
        output in_ready, out_valid, out_mag, out_x, out_y
    );
    modport slave (
        output in_valid, in_sof, in_pix, out_ready,
        input  in_ready, out_valid, out_mag, out_x, out_y
    );
`endif
endinterface

// File: rtl/sobel_sched.sv
// rtl/sobel_sched.sv - sequencer feeding a shared 3x3 gradient unit from a raster stream
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   bus (sobel_sched_if)     pixel input stream and magnitude output stream
//   cv_row_<r>_<c>_o         3x3 window taps (row 0 = line y-2, col 0 = x-2)
//   cv_mode_o                1 = Gx, 0 = Gy
//   cv_y_abs_i               |result| from the conv unit, one cycle after issue
// Optional: SOBEL_THRESH_EN adds bus.thresh / bus.out_edge (edge = sum >= thresh).
module sobel_sched #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 12,
    localparam int XW        = $clog2(IMG_WIDTH),
    localparam int YW        = $clog2(IMG_HEIGHT)
) (
    input  logic                clk,
    input  logic                rst,
    sobel_sched_if.master       bus,
    output logic [12:0]         cv_row_0_0_o,
    output logic [12:0]         cv_row_0_1_o,
    output logic [12:0]         cv_row_0_2_o,
    output logic [12:0]         cv_row_1_0_o,
    output logic [12:0]         cv_row_1_1_o,
    output logic [12:0]         cv_row_1_2_o,
    output logic [12:0]         cv_row_2_0_o,
    output logic [12:0]         cv_row_2_1_o,
    output logic [12:0]         cv_row_2_2_o,
    output logic                cv_mode_o,
    input  logic [17:0]         cv_y_abs_i
);
    typedef enum logic [2:0] {S_IN, S_GX, S_GY, S_SUM, S_OUT} state_t;

    state_t           state_q;
    logic [XW-1:0]    col_q, cx_q;
    logic [YW-1:0]    row_q, cy_q;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] lb0_q [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
    logic [17:0]      gx_q;
    logic             win_ok_q;
    logic             in_ready_q;
    logic             cv_mode_q;
    logic             out_valid_q;
    logic [18:0]      out_mag_q;
    logic [XW-1:0]    out_x_q;
    logic [YW-1:0]    out_y_q;

    logic             accept;
    logic [XW-1:0]    col_cur, col_d;
    logic [YW-1:0]    row_cur, row_d;
    logic [18:0]      sum;

    // in_ready_q is only high in S_IN, so it alone qualifies the transfer
    assign accept  = bus.in_valid & in_ready_q;
    // a start-of-frame pixel is placed at (0,0) regardless of the counters
    assign col_cur = bus.in_sof ? '0 : col_q;
    assign row_cur = bus.in_sof ? '0 : row_q;
    // in S_SUM cv_y_abs_i carries the Gy result issued during S_GY
    assign sum     = {1'b0, gx_q} + {1'b0, cv_y_abs_i};

    always_comb begin
        col_d = col_cur + XW'(1);
        row_d = row_cur;
        if (col_cur == XW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = (row_cur == YW'(IMG_HEIGHT - 1)) ? '0 : row_cur + YW'(1);
        end
    end

    // line buffers carry no reset: every tap read from them is for a window
    // that is only reported once two full lines of the frame have been written
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            lb1_q[col_cur] <= lb0_q[col_cur];
            lb0_q[col_cur] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IN;
            col_q       <= '0;
            row_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            gx_q        <= '0;
            win_ok_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            cv_mode_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            case (state_q)
                S_IN: if (accept) begin
                    for (int r = 0; r < 3; r++) begin
                        win_q[r][0] <= win_q[r][1];
                        win_q[r][1] <= win_q[r][2];
                    end
                    win_q[0][2] <= lb1_q[col_cur];
                    win_q[1][2] <= lb0_q[col_cur];
                    win_q[2][2] <= bus.in_pix;
                    win_ok_q    <= (col_cur >= XW'(2)) && (row_cur >= YW'(2));
                    cx_q        <= col_cur - XW'(1);
                    cy_q        <= row_cur - YW'(1);
                    col_q       <= col_d;
                    row_q       <= row_d;
                    in_ready_q  <= 1'b0;
                    state_q     <= S_GX;
                end
                S_GX: begin
                    cv_mode_q <= 1'b0;
                    state_q   <= S_GY;
                end
                S_GY: begin
                    gx_q      <= cv_y_abs_i;
                    cv_mode_q <= 1'b1;
                    state_q   <= S_SUM;
                end
                S_SUM: begin
                    if (win_ok_q) begin
                        out_mag_q   <= sum;
                        out_x_q     <= cx_q;
                        out_y_q     <= cy_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_IN;
                    end
                end
                S_OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IN;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IN;
                end
            endcase
        end
    end

`ifdef SOBEL_THRESH_EN
    logic edge_q;
    always_ff @(posedge clk) begin
        if (!rst)
            edge_q <= 1'b0;
        else if (state_q == S_SUM && win_ok_q)
            edge_q <= (sum >= bus.thresh);
    end
    assign bus.out_edge = edge_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mag   = out_mag_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign cv_mode_o     = cv_mode_q;

    assign cv_row_0_0_o = 13'(win_q[0][0]);
    assign cv_row_0_1_o = 13'(win_q[0][1]);
    assign cv_row_0_2_o = 13'(win_q[0][2]);
    assign cv_row_1_0_o = 13'(win_q[1][0]);
    assign cv_row_1_1_o = 13'(win_q[1][1]);
    assign cv_row_1_2_o = 13'(win_q[1][2]);
    assign cv_row_2_0_o = 13'(win_q[2][0]);
    assign cv_row_2_1_o = 13'(win_q[2][1]);
    assign cv_row_2_2_o = 13'(win_q[2][2]);
endmodule

// File: tb/tb_sobel_sched.sv
// tb/tb_sobel_sched.sv - scoreboard bench for sobel_sched with a behavioural conv unit
module tb_sobel_sched;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] tap [3][3];
    logic        cv_mode;
    logic [17:0] cv_y_abs = '0;

    sobel_sched_if #(.PIX_W(12), .XW(XW), .YW(YW)) bus ();

    sobel_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(12)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cv_row_0_0_o(tap[0][0]), .cv_row_0_1_o(tap[0][1]), .cv_row_0_2_o(tap[0][2]),
        .cv_row_1_0_o(tap[1][0]), .cv_row_1_1_o(tap[1][1]), .cv_row_1_2_o(tap[1][2]),
        .cv_row_2_0_o(tap[2][0]), .cv_row_2_1_o(tap[2][1]), .cv_row_2_2_o(tap[2][2]),
        .cv_mode_o(cv_mode), .cv_y_abs_i(cv_y_abs)
    );

    always #5 clk = ~clk;

    // behavioural gradient unit: registered |Gx| or |Gy| of the current taps
    function automatic int conv_abs();
        int g;
        if (cv_mode)
            g = (int'(tap[0][2]) + 2*int'(tap[1][2]) + int'(tap[2][2]))
              - (int'(tap[0][0]) + 2*int'(tap[1][0]) + int'(tap[2][0]));
        else
            g = (int'(tap[2][0]) + 2*int'(tap[2][1]) + int'(tap[2][2]))
              - (int'(tap[0][0]) + 2*int'(tap[0][1]) + int'(tap[0][2]));
        return (g < 0) ? -g : g;
    endfunction

    always @(posedge clk) cv_y_abs <= 18'(conv_abs());

    typedef struct { int mag; int x; int y; } exp_t;
    exp_t sbq[$];
    int   img [H][W];
    int   tcol = 0, trow = 0;
    int   checks = 0, errors = 0, nout = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference magnitude computed straight from the stored frame image
    function automatic int ref_mag(input int x, input int y);
        int gx, gy;
        gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
        gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
        return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    endfunction

    task automatic send(input int pix, input bit sof);
        int n;
        exp_t e;
        if (sof) begin tcol = 0; trow = 0; end
        img[trow][tcol] = pix;
        if (tcol >= 2 && trow >= 2) begin
            e.mag = ref_mag(tcol, trow); e.x = tcol - 1; e.y = trow - 1;
            sbq.push_back(e);
        end
        if (tcol == W - 1) begin
            tcol = 0;
            trow = (trow == H - 1) ? 0 : trow + 1;
        end else tcol++;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_pix = 12'(pix); bus.in_sof = sof;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        check(tag, sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            nout++;
            if (sbq.size() == 0) check("unexpected_output", 1, 0);
            else begin
                e = sbq.pop_front();
                check("out_mag", bus.out_mag, e.mag);
                check("out_x", bus.out_x, e.x);
                check("out_y", bus.out_y, e.y);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int base, n, m0, x0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_mag", bus.out_mag, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_cv_mode", cv_mode, 1);
        check("rst_tap", tap[1][1], 0);
        rst = 1'b1;

        // frame 1: flat image, with back-pressure on the first result
        base = nout;
        fork
            for (int i = 0; i < W*H; i++) send(100, i == 0);
            begin
                n = 0;
                while (!bus.out_valid && n < 500) begin @(negedge clk); n++; end
                check("bp_valid_seen", bus.out_valid, 1);
                m0 = bus.out_mag; x0 = bus.out_x;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_hold_valid", bus.out_valid, 1);
                    check("bp_hold_mag", bus.out_mag, m0);
                    check("bp_hold_x", bus.out_x, x0);
                    check("bp_in_ready", bus.in_ready, 0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("flat_drain");
        check("flat_count", nout - base, (W-2)*(H-2));

        // frame 2: vertical step at x=4
        base = nout;
        for (int i = 0; i < W*H; i++) send(((i % W) < 4) ? 0 : 100, i == 0);
        drain("step_drain");
        check("step_count", nout - base, (W-2)*(H-2));

        // frame 3: horizontal step, full-scale top rows
        base = nout;
        for (int i = 0; i < W*H; i++) send(((i / W) <= 2) ? 4095 : 0, i == 0);
        drain("hstep_drain");
        check("hstep_count", nout - base, (W-2)*(H-2));

        // frame 4: restart with in_sof after 20 pixels
        base = nout;
        for (int i = 0; i < 20; i++) send($urandom_range(0, 4095), i == 0);
        drain("pre_sof_drain");
        check("pre_sof_count", nout - base, 2);
        base = nout;
        for (int i = 0; i < W*H; i++) begin
            send($urandom_range(0, 4095), i == 0);
            if (i == 2*W + 1) begin
                repeat (8) @(negedge clk);
                check("sof_no_early_out", nout - base, 0);
            end
            if (i == 2*W + 2) begin
                repeat (8) @(negedge clk);
                check("sof_first_out", nout - base, 1);
            end
        end
        drain("sof_drain");
        check("sof_count", nout - base, (W-2)*(H-2));

        // frame 5: reset while the Gy pass of a valid window is in flight
        for (int i = 0; i < 2*W + 4; i++) send($urandom_range(0, 4095), i == 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        sbq.delete();
        rst = 1'b1;

        // frame 6: fresh random frame after the reset
        base = nout;
        for (int i = 0; i < W*H; i++) send($urandom_range(0, 4095), i == 0);
        drain("post_rst_drain");
        check("post_rst_count", nout - base, (W-2)*(H-2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
